// File: rtl/skin_pipe_pkg.sv
// Shared types and default sizing for the skin-pipe flow controller.
// The defaults mirror the chroma-transform datapath: six edges of latency,
// an eight-entry result FIFO and 16-bit transformed chroma words.
package skin_pipe_pkg;

  localparam int SKIN_PIPE_LAT   = 6;
  localparam int SKIN_PIPE_DEPTH = 8;
  localparam int SKIN_PIPE_OUT_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // One tag per datapath stage: does this slot carry a real beat, and is it
  // the last pixel of its frame.
  typedef struct packed {
    logic valid;
    logic last;
  } tag_t;

endpackage

// File: rtl/skin_pipe_fifo.sv
// Synchronous show-ahead FIFO. The head word is visible whenever the FIFO is
// not empty; push and pop may coincide even when full, and a pop on an empty
// FIFO is ignored. The storage array carries no reset, only the pointers do.
module skin_pipe_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rdata,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign count   = count_q;
  // Empty FIFO presents zeros so the sink never sees stale words.
  assign rdata   = empty ? '0 : mem_q[rd_ptr_q];

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  // Storage write, data only.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/skin_pipe_ctrl.sv
// Flow controller around the free-running transcb/transcr datapath.
// Accepted beats are tagged and the tag travels alongside the datapath for
// LAT edges; when it falls out the datapath result is captured in the output
// FIFO. Credits count both FIFO entries and beats still inside the datapath so
// the FIFO can never overflow. IDLE/RUN/DRAIN delimit frames.
// Optional build macro SKIN_PIPE_STATS_EN adds per-frame pixel/frame counters.
module skin_pipe_ctrl
  import skin_pipe_pkg::*;
#(
  parameter int LAT        = SKIN_PIPE_LAT,
  parameter int FIFO_DEPTH = SKIN_PIPE_DEPTH,
  parameter int OUT_W      = SKIN_PIPE_OUT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_last,
  input  logic [7:0]       in_y,
  input  logic [7:0]       in_cb,
  input  logic [7:0]       in_cr,
  output logic [7:0]       dp_y,
  output logic [7:0]       dp_cb,
  output logic [7:0]       dp_cr,
  input  logic [OUT_W-1:0] dp_transcb,
  input  logic [OUT_W-1:0] dp_transcr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_transcb,
  output logic [OUT_W-1:0] out_transcr,
  output logic             out_last,
`ifdef SKIN_PIPE_STATS_EN
  output logic [23:0]      stat_pixels,
  output logic [15:0]      stat_frames,
  output logic [23:0]      stat_frame_px,
`endif
  output logic             busy
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  state_t               state_q;
  tag_t [LAT-1:0]       tag_q;
  logic [CNT_W-1:0]     inflight_q;
  logic [CNT_W-1:0]     fifo_count;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [CNT_W:0]       committed;
  logic                 accept;
  logic                 push;
  logic                 pop;

  // Credits come from registers only: a pop on this edge frees a slot next cycle.
  assign committed = {1'b0, fifo_count} + {1'b0, inflight_q};
  assign in_ready  = !rst && (state_q != ST_DRAIN) && !fifo_full &&
                     (committed < (CNT_W+1)'(FIFO_DEPTH));
  assign accept    = in_valid && in_ready;

  // The datapath has no enable, so idle cycles feed it zeros.
  assign dp_y  = accept ? in_y  : 8'd0;
  assign dp_cb = accept ? in_cb : 8'd0;
  assign dp_cr = accept ? in_cr : 8'd0;

  assign push      = tag_q[LAT-1].valid;
  assign out_valid = !fifo_empty;
  assign pop       = out_valid && out_ready;
  assign busy      = (state_q != ST_IDLE) || (inflight_q != '0) || !fifo_empty;

  skin_pipe_fifo #(
    .WIDTH (2*OUT_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata ({dp_transcb, dp_transcr, tag_q[LAT-1].last}),
    .pop   (pop),
    .rdata ({out_transcb, out_transcr, out_last}),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Tag shift register tracking which datapath slots hold accepted beats.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_q <= '0;
    end else begin
      tag_q[0] <= '{valid: accept, last: in_last};
      for (int i = 1; i < LAT; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  // Number of accepted beats still travelling through the datapath.
  always_ff @(posedge clk) begin
    if (rst) inflight_q <= '0;
    else     inflight_q <= inflight_q + CNT_W'(accept) - CNT_W'(push);
  end

  // Frame sequencing: DRAIN blocks input until the last beat reaches the FIFO.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:  if (accept) state_q <= in_last ? ST_DRAIN : ST_RUN;
        ST_RUN:   if (accept && in_last) state_q <= ST_DRAIN;
        ST_DRAIN: if ((inflight_q == '0) || ((inflight_q == CNT_W'(1)) && push))
                    state_q <= ST_IDLE;
        default:  state_q <= ST_IDLE;
      endcase
    end
  end

`ifdef SKIN_PIPE_STATS_EN
  // Per-frame pixel count, frame counter and size of the last finished frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_pixels   <= '0;
      stat_frames   <= '0;
      stat_frame_px <= '0;
    end else if (accept) begin
      if (in_last) begin
        stat_pixels   <= '0;
        stat_frames   <= stat_frames + 16'd1;
        stat_frame_px <= stat_pixels + 24'd1;
      end else begin
        stat_pixels   <= stat_pixels + 24'd1;
      end
    end
  end
`endif

endmodule
